// File: rtl/instr_issue.sv
// Instruction issue front end: fetches words, slices fields, owns PC.
// Holds issued fields until instr_done and tracks the extracode latch.
`timescale 1ns/1ps
module instr_issue #(
  parameter int WORD_W = 15,
  parameter int ADDR_W = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(2048)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] pc,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_valid,
  input  logic              ext_flag,
  input  logic              instr_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              issue_valid,
  output logic [2:0]        opcode,
  output logic [1:0]        qc,
  output logic [ADDR_W-1:0] addr,
  output logic              extracode
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetch_req_q, fetch_req_d;
  logic              issue_valid_q, issue_valid_d;
  logic              extracode_q, extracode_d;
  logic              ext_pend_q, ext_pend_d;
  logic [2:0]        opcode_q, opcode_d;
  logic [1:0]        qc_q, qc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_req_d   = fetch_req_q;
    issue_valid_d = issue_valid_q;
    extracode_d   = extracode_q;
    ext_pend_d    = ext_pend_q;
    opcode_d      = opcode_q;
    qc_d          = qc_q;
    addr_d        = addr_q;
    unique case (state_q)
      S_FETCH: begin
        fetch_req_d = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid) begin
          opcode_d      = mem_rdata[WORD_W-1 -: 3];
          qc_d          = mem_rdata[ADDR_W-1 -: 2];
          addr_d        = mem_rdata[ADDR_W-1:0];
          extracode_d   = ext_pend_q;
          ext_pend_d    = 1'b0;
          fetch_req_d   = 1'b0;
          issue_valid_d = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        // EXTEND marks the next word, so it stays pending across done
        if (ext_flag) ext_pend_d = 1'b1;
        if (instr_done) begin
          issue_valid_d = 1'b0;
          extracode_d   = 1'b0;
          pc_d          = pc_load ? pc_in : pc_q + ADDR_W'(1);
          state_d       = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      fetch_req_q   <= 1'b0;
      issue_valid_q <= 1'b0;
      extracode_q   <= 1'b0;
      ext_pend_q    <= 1'b0;
      opcode_q      <= '0;
      qc_q          <= '0;
      addr_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_req_q   <= fetch_req_d;
      issue_valid_q <= issue_valid_d;
      extracode_q   <= extracode_d;
      ext_pend_q    <= ext_pend_d;
      opcode_q      <= opcode_d;
      qc_q          <= qc_d;
      addr_q        <= addr_d;
    end
  end

  assign fetch_req   = fetch_req_q;
  assign pc          = pc_q;
  assign issue_valid = issue_valid_q;
  assign extracode   = extracode_q;
  assign opcode      = opcode_q;
  assign qc          = qc_q;
  assign addr        = addr_q;

endmodule

// File: tb/tb_instr_issue.sv
// Directed testbench for instr_issue.
// Inputs change 1ns after posedge; outputs are checked there too.
`timescale 1ns/1ps
module tb_instr_issue;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [11:0] pc;
  logic [14:0] mem_rdata;
  logic        mem_valid;
  logic        ext_flag;
  logic        instr_done;
  logic        pc_load;
  logic [11:0] pc_in;
  logic        issue_valid;
  logic [2:0]  opcode;
  logic [1:0]  qc;
  logic [11:0] addr;
  logic        extracode;

  int n_cmp;
  int n_bad;

  instr_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_req  (fetch_req),
    .pc         (pc),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .ext_flag   (ext_flag),
    .instr_done (instr_done),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .issue_valid(issue_valid),
    .opcode     (opcode),
    .qc         (qc),
    .addr       (addr),
    .extracode  (extracode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one word for a single cycle while in WAIT
  task automatic give_word(input logic [14:0] w);
    mem_rdata = w;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
  endtask

  task automatic finish_instr(input logic ld, input logic [11:0] tgt);
    instr_done = 1'b1;
    pc_load    = ld;
    pc_in      = tgt;
    tick();
    instr_done = 1'b0;
    pc_load    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_rdata = '0; mem_valid = 0; ext_flag = 0;
    instr_done = 0; pc_load = 0; pc_in = '0;
    tick(); tick();
    n_cmp++;
    if ({fetch_req, issue_valid, extracode, pc} !== {3'b000, 12'd2048}) begin
      n_bad++;
      $display("FAIL reset_state got fr=%0b iv=%0b ex=%0b pc=%0d want 0 0 0 2048",
               fetch_req, issue_valid, extracode, pc);
    end
    n_cmp++;
    if ({opcode, qc, addr} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_fields got op=%0d qc=%0d addr=%0d want 0 0 0",
               opcode, qc, addr);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({fetch_req, issue_valid, pc} !== {2'b10, 12'd2048}) begin
      n_bad++;
      $display("FAIL first_fetch got fr=%0b iv=%0b pc=%0d want 1 0 2048",
               fetch_req, issue_valid, pc);
    end
    tick(); tick(); tick();
    n_cmp++;
    if ({fetch_req, issue_valid, extracode} !== 3'b100) begin
      n_bad++;
      $display("FAIL idle_mem got fr=%0b iv=%0b ex=%0b want 1 0 0",
               fetch_req, issue_valid, extracode);
    end
  endtask

  task automatic test_basic();
    give_word(15'b111_00_0000000101);
    n_cmp++;
    if ({issue_valid, opcode, qc, addr, extracode, fetch_req}
        !== {1'b1, 3'd7, 2'd0, 12'd5, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_issue got iv=%0b op=%0d qc=%0d addr=%0d ex=%0b fr=%0b want 1 7 0 5 0 0",
               issue_valid, opcode, qc, addr, extracode, fetch_req);
    end
    mem_rdata = 15'b000_11_1111111111;
    tick(); tick();
    n_cmp++;
    if ({issue_valid, opcode, addr} !== {1'b1, 3'd7, 12'd5}) begin
      n_bad++;
      $display("FAIL basic_hold got iv=%0b op=%0d addr=%0d want 1 7 5",
               issue_valid, opcode, addr);
    end
    finish_instr(1'b0, 12'd0);
    n_cmp++;
    if ({issue_valid, pc} !== {1'b0, 12'd2049}) begin
      n_bad++;
      $display("FAIL basic_done got iv=%0b pc=%0d want 0 2049", issue_valid, pc);
    end
    tick();
    n_cmp++;
    if ({fetch_req, pc} !== {1'b1, 12'd2049}) begin
      n_bad++;
      $display("FAIL basic_refetch got fr=%0b pc=%0d want 1 2049", fetch_req, pc);
    end
  endtask

  task automatic test_extend();
    give_word(15'b010_00_0000001010);
    n_cmp++;
    if ({opcode, addr, extracode} !== {3'd2, 12'd10, 1'b0}) begin
      n_bad++;
      $display("FAIL ext_word0 got op=%0d addr=%0d ex=%0b want 2 10 0",
               opcode, addr, extracode);
    end
    ext_flag = 1'b1;
    tick();
    ext_flag = 1'b0;
    tick();
    finish_instr(1'b0, 12'd0);
    n_cmp++;
    if ({pc, extracode} !== {12'd2050, 1'b0}) begin
      n_bad++;
      $display("FAIL ext_done0 got pc=%0d ex=%0b want 2050 0", pc, extracode);
    end
    tick();
    give_word(15'b101_01_0000000000);
    n_cmp++;
    if ({opcode, qc, addr, extracode} !== {3'd5, 2'd1, 12'd1024, 1'b1}) begin
      n_bad++;
      $display("FAIL ext_word1 got op=%0d qc=%0d addr=%0d ex=%0b want 5 1 1024 1",
               opcode, qc, addr, extracode);
    end
    finish_instr(1'b0, 12'd0);
    n_cmp++;
    if ({issue_valid, extracode} !== 2'b00) begin
      n_bad++;
      $display("FAIL ext_clear got iv=%0b ex=%0b want 0 0", issue_valid, extracode);
    end
    tick();
    give_word(15'b011_11_1111111111);
    n_cmp++;
    if ({opcode, qc, addr, extracode, pc} !== {3'd3, 2'd3, 12'd4095, 1'b0, 12'd2051}) begin
      n_bad++;
      $display("FAIL ext_word2 got op=%0d qc=%0d addr=%0d ex=%0b pc=%0d want 3 3 4095 0 2051",
               opcode, qc, addr, extracode, pc);
    end
  endtask

  task automatic test_ext_simul();
    ext_flag = 1'b1;
    finish_instr(1'b0, 12'd0);
    ext_flag = 1'b0;
    tick();
    give_word(15'b001_00_0000000001);
    n_cmp++;
    if ({opcode, extracode, pc} !== {3'd1, 1'b1, 12'd2052}) begin
      n_bad++;
      $display("FAIL ext_simul got op=%0d ex=%0b pc=%0d want 1 1 2052",
               opcode, extracode, pc);
    end
    ext_flag = 1'b1;
    tick();
    ext_flag = 1'b0;
    finish_instr(1'b0, 12'd0);
    tick();
    give_word(15'b110_10_0000000010);
    n_cmp++;
    if ({opcode, qc, extracode, pc} !== {3'd6, 2'd2, 1'b1, 12'd2053}) begin
      n_bad++;
      $display("FAIL ext_rearm got op=%0d qc=%0d ex=%0b pc=%0d want 6 2 1 2053",
               opcode, qc, extracode, pc);
    end
  endtask

  task automatic test_branch_wrap();
    pc_load = 1'b1;
    pc_in   = 12'd100;
    tick();
    pc_load = 1'b0;
    n_cmp++;
    if ({pc, issue_valid} !== {12'd2053, 1'b1}) begin
      n_bad++;
      $display("FAIL load_no_done got pc=%0d iv=%0b want 2053 1", pc, issue_valid);
    end
    finish_instr(1'b1, 12'd4095);
    n_cmp++;
    if (pc !== 12'd4095) begin
      n_bad++;
      $display("FAIL branch got pc=%0d want 4095", pc);
    end
    tick();
    give_word(15'b100_00_0000000011);
    finish_instr(1'b0, 12'd77);
    n_cmp++;
    if (pc !== 12'd0) begin
      n_bad++;
      $display("FAIL wrap got pc=%0d want 0", pc);
    end
  endtask

  task automatic test_stall();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({fetch_req, issue_valid} !== 2'b10) begin
        n_bad++;
        $display("FAIL stall_%0d got fr=%0b iv=%0b want 1 0", i, fetch_req, issue_valid);
      end
    end
    instr_done = 1'b1;
    pc_load    = 1'b1;
    pc_in      = 12'd123;
    ext_flag   = 1'b1;
    tick();
    instr_done = 1'b0;
    pc_load    = 1'b0;
    ext_flag   = 1'b0;
    n_cmp++;
    if ({fetch_req, issue_valid, pc} !== {2'b10, 12'd0}) begin
      n_bad++;
      $display("FAIL stray_done got fr=%0b iv=%0b pc=%0d want 1 0 0",
               fetch_req, issue_valid, pc);
    end
    give_word(15'b011_00_0000000111);
    n_cmp++;
    if ({issue_valid, opcode, addr, extracode} !== {1'b1, 3'd3, 12'd7, 1'b0}) begin
      n_bad++;
      $display("FAIL stall_issue got iv=%0b op=%0d addr=%0d ex=%0b want 1 3 7 0",
               issue_valid, opcode, addr, extracode);
    end
    mem_rdata = 15'b111_11_0000001111;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    n_cmp++;
    if ({opcode, qc, addr} !== {3'd3, 2'd0, 12'd7}) begin
      n_bad++;
      $display("FAIL exec_ignore_mem got op=%0d qc=%0d addr=%0d want 3 0 7",
               opcode, qc, addr);
    end
  endtask

  task automatic test_reset_mid();
    ext_flag = 1'b1;
    tick();
    ext_flag = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({fetch_req, issue_valid, extracode, pc, opcode, qc, addr}
        !== {3'b000, 12'd2048, 17'd0}) begin
      n_bad++;
      $display("FAIL async_reset got fr=%0b iv=%0b ex=%0b pc=%0d op=%0d qc=%0d addr=%0d",
               fetch_req, issue_valid, extracode, pc, opcode, qc, addr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({fetch_req, pc} !== {1'b1, 12'd2048}) begin
      n_bad++;
      $display("FAIL post_reset_fetch got fr=%0b pc=%0d want 1 2048", fetch_req, pc);
    end
    give_word(15'b010_01_0000000001);
    n_cmp++;
    if ({issue_valid, opcode, qc, extracode} !== {1'b1, 3'd2, 2'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL post_reset_ext got iv=%0b op=%0d qc=%0d ex=%0b want 1 2 1 0",
               issue_valid, opcode, qc, extracode);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_extend();
    test_ext_simul();
    test_branch_wrap();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Front end of the instruction sequencer: fetches 15-bit instruction words from memory and slices them into opcode, qc and address fields.
- Presents those fields to the control-pulse generator and holds them stable until that generator signals end of instruction.
- Owns the program counter and the extracode latch: an ext_flag raised while an EXTEND executes marks the next instruction as extracode.

Parameters:
- WORD_W, 15, instruction word width.
- ADDR_W, 12, address field and PC width.
- RESET_PC, 2048 (octal 4000), PC value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_req  output  1  memory read request, held until mem_valid.
- pc  output  ADDR_W  fetch address; current program counter.
- mem_rdata  input  WORD_W  instruction word from memory.
- mem_valid  input  1  mem_rdata valid this cycle.
- ext_flag  input  1  EXTEND seen by the control-pulse generator.
- instr_done  input  1  one-cycle end-of-instruction strobe from the control-pulse generator.
- pc_load  input  1  branch taken; qualified by instr_done.
- pc_in  input  ADDR_W  branch target.
- issue_valid  output  1  opcode/qc/extracode/addr valid and held.
- opcode  output  3  mem_rdata[14:12] of the issued word.
- qc  output  2  mem_rdata[11:10].
- addr  output  ADDR_W  mem_rdata[11:0].
- extracode  output  1  issued instruction is an extracode.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; pc=RESET_PC.
  - fetch_req=0, issue_valid=0, extracode=0, ext_pend=0.
  - opcode=0, qc=0, addr=0.
  - First rising edge after release raises fetch_req.
- States:
  - FETCH: drive fetch_req=1 with pc; go to WAIT next cycle.
  - WAIT: keep fetch_req=1. On mem_valid:
    - latch opcode, qc and addr from mem_rdata;
    - extracode <= ext_pend, ext_pend <= 0;
    - fetch_req <= 0, issue_valid <= 1;
    - go to EXEC.
  - EXEC: hold all issued fields constant.
    - ext_flag=1 on any cycle sets ext_pend (sticky).
    - On instr_done: issue_valid <= 0, extracode <= 0.
    - pc <= pc_in if pc_load, else pc+1.
    - Go to FETCH.
- Latency:
  - Minimum from instr_done to next issue_valid is 3 edges (FETCH, WAIT with same-cycle mem_valid, issue).
  - mem_valid may be delayed arbitrarily; WAIT holds with no timeout.
- PC arithmetic: modulo 2^ADDR_W; 4095+1 wraps to 0. pc_load without instr_done is ignored.
- Simultaneous events:
  - ext_flag and instr_done in the same EXEC cycle: ext_pend is set; the next instruction issues with extracode=1.
  - EXTEND executed while extracode=1: ext_pend is re-armed; the following instruction is also an extracode.
  - pc_load and instr_done together: pc_in wins.
- Ignored inputs:
  - mem_valid outside WAIT.
  - instr_done outside EXEC.
  - ext_flag outside EXEC (ext_pend unchanged).
- Reset mid-operation: any state returns immediately to the reset values above; a pending ext_pend is lost.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle memory: rst_n low→high → fetch_req=1 at pc=2048 on the first edge; issue_valid=0, extracode=0 throughout.
- Basic issue: mem_rdata=15'b111_00_0000000101 (opcode 7) with mem_valid in WAIT → next edge opcode=7, qc=0, addr=5, issue_valid=1, extracode=0. instr_done → issue_valid=0, pc=2049, fetch_req=1.
- Extend sequence: ext_flag pulsed during EXEC of word 0 → next word 15'b101_01_0000000000 issues opcode=5, qc=1, extracode=1. Its instr_done clears extracode; the third instruction issues with extracode=0.
- Branch and wrap:
  - instr_done with pc_load=1, pc_in=4095 → pc=4095.
  - Next instr_done with pc_load=0 → pc=0.
- Memory stall and stray strobes: hold mem_valid low 5 cycles → fetch_req stays 1 and state stays WAIT. Pulse instr_done during WAIT → no change.
- Reset mid-EXEC with ext_pend=1: assert rst_n=0 → outputs return to reset values asynchronously. After release, the first issued instruction has extracode=0.
